// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg
//   Shared types and constants for the register-file port arbiter.
//   NUM_REGS   : number of architectural registers cleared by the init sweep
//   state_e    : sequencer state (clear sweep / normal arbitration)
//   gnt_e      : which requester owns the register-file port this cycle
//   onehot_to_gnt : maps the {dbg, rd, wb} one-hot grant to gnt_e
package regfile_arb_pkg;

    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;
    localparam logic [REG_AW-1:0] LAST_REG = REG_AW'(NUM_REGS - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WB,
        GNT_RD,
        GNT_DBG
    } gnt_e;

    // Bit 0 = wb, bit 1 = rd, bit 2 = dbg. At most one bit is ever set.
    function automatic gnt_e onehot_to_gnt(input logic [2:0] oh);
        gnt_e g;
        g = GNT_NONE;
        if (oh[0])      g = GNT_WB;
        else if (oh[1]) g = GNT_RD;
        else if (oh[2]) g = GNT_DBG;
        return g;
    endfunction

endpackage

// File: rtl/regfile_arb_prio.sv
// regfile_arb_prio
//   Combinational three-way priority pick used by shared-resource arbiters.
//   Normal order is valid[0] > valid[1] > valid[2]; when starve is set the
//   lowest-priority requester (valid[2]) jumps to the front.
//   Ports:
//     valid  in  3 : request valids, index 0 = highest normal priority
//     starve in  1 : promote requester 2 to top priority
//     grant  out 3 : one-hot grant (all zero when nothing is valid)
module regfile_arb_prio (
    input  logic [2:0] valid,
    input  logic       starve,
    output logic [2:0] grant
);

    always_comb begin
        grant = 3'b000;
        if (starve && valid[2])
            grant = 3'b100;
        else if (valid[0])
            grant = 3'b001;
        else if (valid[1])
            grant = 3'b010;
        else if (valid[2])
            grant = 3'b100;
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
//   Owns the single port of the register file. After reset it clears
//   x0..x31 with a 32-cycle write sweep, then each cycle grants the port to
//   one of core writeback (wb), core operand read (rd) or debug (dbg).
//   The port does either one write or one two-register read per cycle.
//
//   Build option: define REGFILE_ARB_DEBUG_EN to build the debug port and the
//   starvation counter. Without it the debug outputs are tied to 0, debug
//   inputs are ignored and priority is fixed at wb > rd.
//
//   Ports:
//     i_clk, i_reset                 clock, async active-high reset
//     i_wb_*, o_wb_ready             writeback request / accept
//     i_rd_*, o_rd_ready             operand read request / accept
//     o_rd_rvalid, o_rd_data_1/2     operand read response (1 cycle after grant)
//     i_dbg_*, o_dbg_ready           debug request / accept
//     o_dbg_rvalid, o_dbg_rdata      debug read response
//     o_rf_*                         register file write/read controls
//     i_rf_read_data_1/2             register file read data (registered in RF)
//     o_init_done                    clear sweep complete
module regfile_port_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,

    input  logic            i_wb_valid,
    input  logic [4:0]      i_wb_addr,
    input  logic [XLEN-1:0] i_wb_data,
    output logic            o_wb_ready,

    input  logic            i_rd_valid,
    input  logic [4:0]      i_rd_addr_1,
    input  logic [4:0]      i_rd_addr_2,
    output logic            o_rd_ready,
    output logic            o_rd_rvalid,
    output logic [XLEN-1:0] o_rd_data_1,
    output logic [XLEN-1:0] o_rd_data_2,

    input  logic            i_dbg_valid,
    input  logic            i_dbg_write,
    input  logic [4:0]      i_dbg_addr,
    input  logic [XLEN-1:0] i_dbg_wdata,
    output logic            o_dbg_ready,
    output logic            o_dbg_rvalid,
    output logic [XLEN-1:0] o_dbg_rdata,

    output logic            o_rf_we,
    output logic [4:0]      o_rf_write_register,
    output logic [XLEN-1:0] o_rf_write_data,
    output logic [4:0]      o_rf_read_register_1,
    output logic [4:0]      o_rf_read_register_2,
    input  logic [XLEN-1:0] i_rf_read_data_1,
    input  logic [XLEN-1:0] i_rf_read_data_2,

    output logic            o_init_done
);

    state_e          state;
    logic [4:0]      index;
    logic            init_done;

    logic            dbg_valid_g;
    logic            dbg_write_g;
    logic [4:0]      dbg_addr_g;
    logic [XLEN-1:0] dbg_wdata_g;
    logic            starve;

    logic            in_run;
    logic [2:0]      req;
    logic [2:0]      grant;
    gnt_e            gnt_sel;

    logic            rf_we_c;
    logic [4:0]      wreg_c;
    logic [XLEN-1:0] wdata_c;

    logic            rd_issue;
    logic [4:0]      raddr1_c;
    logic [4:0]      raddr2_c;
    logic [4:0]      raddr1_hold_p1;
    logic [4:0]      raddr2_hold_p1;

    logic            rd_rvalid_p1;
    logic            dbg_rvalid_p1;

`ifdef REGFILE_ARB_DEBUG_EN
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;

    assign dbg_valid_g = i_dbg_valid;
    assign dbg_write_g = i_dbg_write;
    assign dbg_addr_g  = i_dbg_addr;
    assign dbg_wdata_g = i_dbg_wdata;
    assign starve      = (starve_cnt == STARVE_MAX);

    // Counts run-state cycles debug spent waiting; saturates so the promotion
    // holds until debug is actually served.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            starve_cnt <= 4'd0;
        end else if (grant[2]) begin
            starve_cnt <= 4'd0;
        end else if (in_run && i_dbg_valid && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign o_dbg_rdata = i_rf_read_data_1;
`else
    // Debug inputs are deliberately left unconnected in this build.
    logic unused_dbg;
    assign unused_dbg  = ^{i_dbg_valid, i_dbg_write, i_dbg_addr, i_dbg_wdata};

    assign dbg_valid_g = 1'b0;
    assign dbg_write_g = 1'b0;
    assign dbg_addr_g  = 5'd0;
    assign dbg_wdata_g = '0;
    assign starve      = 1'b0;
    assign o_dbg_rdata = '0;
`endif

    // Arbitration: nobody is served while the clear sweep owns the port.
    assign in_run = (state == ST_RUN);
    assign req    = in_run ? {dbg_valid_g, i_rd_valid, i_wb_valid} : 3'b000;

    regfile_arb_prio u_prio (
        .valid  (req),
        .starve (starve),
        .grant  (grant)
    );

    assign gnt_sel     = onehot_to_gnt(grant);
    assign o_wb_ready  = grant[0];
    assign o_rd_ready  = grant[1];
    assign o_dbg_ready = grant[2];

    // Write side: sweep writes, or the granted write. Writes to x0 are
    // accepted but never reach the array so x0 stays zero.
    always_comb begin
        rf_we_c = 1'b0;
        wreg_c  = 5'd0;
        wdata_c = '0;
        if (state == ST_INIT) begin
            rf_we_c = 1'b1;
            wreg_c  = index;
        end else begin
            case (gnt_sel)
                GNT_WB: begin
                    rf_we_c = (i_wb_addr != 5'd0);
                    wreg_c  = i_wb_addr;
                    wdata_c = i_wb_data;
                end
                GNT_DBG: begin
                    if (dbg_write_g) begin
                        rf_we_c = (dbg_addr_g != 5'd0);
                        wreg_c  = dbg_addr_g;
                        wdata_c = dbg_wdata_g;
                    end
                end
                default: ;
            endcase
        end
    end

    // The asynchronous reset only settles state on the next edge evaluation,
    // so the write enable is masked directly while reset is held.
    assign o_rf_we             = rf_we_c & ~i_reset;
    assign o_rf_write_register = wreg_c;
    assign o_rf_write_data     = wdata_c;

    // Read side: debug reads present the same address on both ports.
    assign rd_issue = grant[1] | (grant[2] & ~dbg_write_g);
    assign raddr1_c = grant[1] ? i_rd_addr_1 : dbg_addr_g;
    assign raddr2_c = grant[1] ? i_rd_addr_2 : dbg_addr_g;

    assign o_rf_read_register_1 = rd_issue ? raddr1_c : raddr1_hold_p1;
    assign o_rf_read_register_2 = rd_issue ? raddr2_c : raddr2_hold_p1;

    // ---- stage p1: remembered read address, read response valids ----
    always_ff @(posedge i_clk) begin
        if (rd_issue) begin
            raddr1_hold_p1 <= raddr1_c;
            raddr2_hold_p1 <= raddr2_c;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rd_rvalid_p1  <= 1'b0;
            dbg_rvalid_p1 <= 1'b0;
        end else begin
            rd_rvalid_p1  <= grant[1];
            dbg_rvalid_p1 <= grant[2] & ~dbg_write_g;
        end
    end

    assign o_rd_rvalid  = rd_rvalid_p1;
    assign o_dbg_rvalid = dbg_rvalid_p1;
    // The register file already registers its read data; pass it through.
    assign o_rd_data_1  = i_rf_read_data_1;
    assign o_rd_data_2  = i_rf_read_data_2;

    // Sequencer: clear sweep over all registers, then arbitrate forever.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= ST_INIT;
            index     <= 5'd0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    index <= index + 5'd1;
                    if (index == LAST_REG) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign o_init_done = init_done;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter
//   Directed bench for regfile_port_arbiter with a small behavioural register
//   file (registered read data) attached to the arbiter's port.
module tb_regfile_port_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;

    logic            wb_valid = 1'b0;
    logic [4:0]      wb_addr  = 5'd0;
    logic [XLEN-1:0] wb_data  = '0;
    logic            wb_ready;

    logic            rd_valid  = 1'b0;
    logic [4:0]      rd_addr_1 = 5'd0;
    logic [4:0]      rd_addr_2 = 5'd0;
    logic            rd_ready;
    logic            rd_rvalid;
    logic [XLEN-1:0] rd_data_1;
    logic [XLEN-1:0] rd_data_2;

    logic            dbg_valid = 1'b0;
    logic            dbg_write = 1'b0;
    logic [4:0]      dbg_addr  = 5'd0;
    logic [XLEN-1:0] dbg_wdata = '0;
    logic            dbg_ready;
    logic            dbg_rvalid;
    logic [XLEN-1:0] dbg_rdata;

    logic            rf_we;
    logic [4:0]      rf_wreg;
    logic [XLEN-1:0] rf_wdata;
    logic [4:0]      rf_rreg_1;
    logic [4:0]      rf_rreg_2;
    logic [XLEN-1:0] rf_rdata_1 = '0;
    logic [XLEN-1:0] rf_rdata_2 = '0;
    logic            init_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
        .i_clk                (clk),
        .i_reset              (rst),
        .i_wb_valid           (wb_valid),
        .i_wb_addr            (wb_addr),
        .i_wb_data            (wb_data),
        .o_wb_ready           (wb_ready),
        .i_rd_valid           (rd_valid),
        .i_rd_addr_1          (rd_addr_1),
        .i_rd_addr_2          (rd_addr_2),
        .o_rd_ready           (rd_ready),
        .o_rd_rvalid          (rd_rvalid),
        .o_rd_data_1          (rd_data_1),
        .o_rd_data_2          (rd_data_2),
        .i_dbg_valid          (dbg_valid),
        .i_dbg_write          (dbg_write),
        .i_dbg_addr           (dbg_addr),
        .i_dbg_wdata          (dbg_wdata),
        .o_dbg_ready          (dbg_ready),
        .o_dbg_rvalid         (dbg_rvalid),
        .o_dbg_rdata          (dbg_rdata),
        .o_rf_we              (rf_we),
        .o_rf_write_register  (rf_wreg),
        .o_rf_write_data      (rf_wdata),
        .o_rf_read_register_1 (rf_rreg_1),
        .o_rf_read_register_2 (rf_rreg_2),
        .i_rf_read_data_1     (rf_rdata_1),
        .i_rf_read_data_2     (rf_rdata_2),
        .o_init_done          (init_done)
    );

    // Register file model: nonzero power-up contents so the sweep is visible.
    logic [XLEN-1:0] regs [32];
    logic            seeded = 1'b0;

    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'hA500_0000 + i;
            seeded <= 1'b1;
        end else if (rf_we) begin
            regs[rf_wreg] <= rf_wdata;
        end
        rf_rdata_1 <= regs[rf_rreg_1];
        rf_rdata_2 <= regs[rf_rreg_2];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held: everything quiet even with a request pending.
        wb_valid = 1'b1;
        wb_addr  = 5'd7;
        wb_data  = 32'h0000_00FF;
        tick();
        tick();
        #1;
        chk("rst_we", rf_we, 0);
        chk("rst_wb_ready", wb_ready, 0);
        chk("rst_rvalid", rd_rvalid, 0);
        chk("rst_dbg_rvalid", dbg_rvalid, 0);
        chk("rst_init_done", init_done, 0);

        // Clear sweep: 32 cycles writing 0 to x0..x31, no readies.
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            wb_valid = (k < 31);
            #1;
            chk("sweep_we", rf_we, 1);
            chk("sweep_addr", rf_wreg, k);
            chk("sweep_data", rf_wdata, 0);
            chk("sweep_wb_ready", wb_ready, 0);
            chk("sweep_done_low", init_done, 0);
            tick();
        end
        chk("init_done", init_done, 1);

        // Read x5/x6 after the sweep: both cleared.
        rd_valid  = 1'b1;
        rd_addr_1 = 5'd5;
        rd_addr_2 = 5'd6;
        #1;
        chk("rd5_ready", rd_ready, 1);
        chk("rd5_we", rf_we, 0);
        chk("rd5_raddr", rf_rreg_1, 5);
        tick();
        rd_valid = 1'b0;
        #1;
        chk("rd5_rvalid", rd_rvalid, 1);
        chk("rd5_data1", rd_data_1, 0);
        chk("rd5_data2", rd_data_2, 0);
        tick();
        chk("rd5_rvalid_once", rd_rvalid, 0);

        // Writeback x3 with a read of x3 in the same cycle: wb first.
        wb_valid  = 1'b1;
        wb_addr   = 5'd3;
        wb_data   = 32'hDEAD_BEEF;
        rd_valid  = 1'b1;
        rd_addr_1 = 5'd3;
        rd_addr_2 = 5'd0;
        #1;
        chk("wb3_ready", wb_ready, 1);
        chk("wb3_rd_blocked", rd_ready, 0);
        chk("wb3_we", rf_we, 1);
        chk("wb3_wreg", rf_wreg, 3);
        chk("wb3_wdata", rf_wdata, 32'hDEAD_BEEF);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("rd3_ready", rd_ready, 1);
        chk("rd3_we", rf_we, 0);
        tick();
        rd_valid = 1'b0;
        #1;
        chk("rd3_rvalid", rd_rvalid, 1);
        chk("rd3_data1", rd_data_1, 32'hDEAD_BEEF);
        chk("rd3_data2", rd_data_2, 0);

        // Write to x0 is accepted but suppressed.
        wb_valid = 1'b1;
        wb_addr  = 5'd0;
        wb_data  = 32'h0000_1234;
        #1;
        chk("wb0_ready", wb_ready, 1);
        chk("wb0_we", rf_we, 0);
        tick();
        wb_valid  = 1'b0;
        rd_valid  = 1'b1;
        rd_addr_1 = 5'd0;
        rd_addr_2 = 5'd3;
        #1;
        chk("rd0_ready", rd_ready, 1);
        tick();
        rd_valid = 1'b0;
        #1;
        chk("rd0_data1", rd_data_1, 0);
        chk("rd0_data2", rd_data_2, 32'hDEAD_BEEF);
        chk("idle_hold_raddr1", rf_rreg_1, 0);
        chk("idle_hold_raddr2", rf_rreg_2, 3);
        chk("idle_we", rf_we, 0);
        tick();

`ifdef REGFILE_ARB_DEBUG_EN
        // Debug read starved by continuous writeback: served on 5th cycle.
        wb_valid  = 1'b1;
        wb_addr   = 5'd9;
        wb_data   = 32'h0000_0909;
        dbg_valid = 1'b1;
        dbg_write = 1'b0;
        dbg_addr  = 5'd3;
        for (int c = 1; c <= 4; c++) begin
            #1;
            chk("starve_dbg_ready", dbg_ready, 0);
            chk("starve_wb_ready", wb_ready, 1);
            tick();
        end
        #1;
        chk("dbg_ready_c5", dbg_ready, 1);
        chk("dbg_wb_held", wb_ready, 0);
        chk("dbg_we", rf_we, 0);
        chk("dbg_raddr1", rf_rreg_1, 3);
        chk("dbg_raddr2", rf_rreg_2, 3);
        tick();
        dbg_valid = 1'b0;
        wb_valid  = 1'b0;
        #1;
        chk("dbg_rvalid", dbg_rvalid, 1);
        chk("dbg_rdata", dbg_rdata, 32'hDEAD_BEEF);
        chk("dbg_rd_rvalid", rd_rvalid, 0);
        tick();
        chk("dbg_rvalid_once", dbg_rvalid, 0);
`else
        // Debug disabled: debug never granted, reads proceed as normal.
        dbg_valid = 1'b1;
        dbg_write = 1'b1;
        dbg_addr  = 5'd4;
        dbg_wdata = 32'h0BAD_0BAD;
        rd_valid  = 1'b1;
        rd_addr_1 = 5'd3;
        rd_addr_2 = 5'd5;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("nodbg_dbg_ready", dbg_ready, 0);
            chk("nodbg_rd_ready", rd_ready, 1);
            chk("nodbg_we", rf_we, 0);
            tick();
        end
        rd_valid  = 1'b0;
        dbg_valid = 1'b0;
        #1;
        chk("nodbg_rd_rvalid", rd_rvalid, 1);
        chk("nodbg_rd_data1", rd_data_1, 32'hDEAD_BEEF);
        chk("nodbg_dbg_rvalid", dbg_rvalid, 0);
        chk("nodbg_dbg_rdata", dbg_rdata, 0);
        tick();
`endif

        // Reset with a read response pending drops it immediately.
        rd_valid  = 1'b1;
        rd_addr_1 = 5'd3;
        rd_addr_2 = 5'd3;
        #1;
        chk("pre_rst_rd_ready", rd_ready, 1);
        tick();
        rd_valid = 1'b0;
        chk("pre_rst_rvalid", rd_rvalid, 1);
        rst = 1'b1;
        #1;
        chk("rst_drop_rvalid", rd_rvalid, 0);
        chk("rst_drop_done", init_done, 0);
        chk("rst_drop_we", rf_we, 0);
        tick();
        rst = 1'b0;

        // Sweep interrupted at index 10 restarts from index 0.
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("sweep2_addr", rf_wreg, k);
            tick();
        end
        chk("sweep2_at10", rf_wreg, 10);
        rst = 1'b1;
        #1;
        chk("sweep2_rst_we", rf_we, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("sweep3_restart_we", rf_we, 1);
        chk("sweep3_restart_addr", rf_wreg, 0);
        for (int k = 0; k < 32; k++) begin
            #1;
            chk("sweep3_addr", rf_wreg, k);
            chk("sweep3_rvalid", rd_rvalid, 0);
            tick();
        end
        chk("sweep3_done", init_done, 1);

        // x3 was cleared again by the restarted sweep.
        rd_valid  = 1'b1;
        rd_addr_1 = 5'd3;
        rd_addr_2 = 5'd31;
        #1;
        chk("final_rd_ready", rd_ready, 1);
        tick();
        rd_valid = 1'b0;
        #1;
        chk("final_rvalid", rd_rvalid, 1);
        chk("final_data1", rd_data_1, 0);
        chk("final_data2", rd_data_2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
